pipe_elastic_reg_t: RTL

Parametrised elastic pipeline register: a chain of `STAGES` skid-buffered register stages with valid/ready handshaking on both sides. It also has a global CLEAR (flush), a global STALL (freeze) and an occupancy count. It is the handshaked successor of the single-stage stall/clear/write-enable flop. It sits between producer and consumer pipeline sections, such as fetch→decode or execute→memory, wherever backpressure must be cut with registered ready signals.

---
 rtl/pipe_elastic_reg_t_pkg.sv | 17 +
 rtl/pipe_elastic_reg_t_skid.sv | 76 +++++++
 rtl/pipe_elastic_reg_t.sv | 80 ++++++++
 3 files changed

// File: rtl/pipe_elastic_reg_t_pkg.sv
// Shared helpers for the elastic pipeline register.
package pipe_elastic_reg_t_pkg;

  // Next occupancy value from the current count and the two handshake strobes.
  // Both or neither strobes leave the count unchanged.
  function automatic int occ_next(input int cur, input logic inc, input logic dec);
    int nxt;
    nxt = cur;
    case ({inc, dec})
      2'b10:   nxt = cur + 1;
      2'b01:   nxt = cur - 1;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_elastic_reg_t_skid.sv
// One skid-buffered stage: main register plus skid register, each with a
// valid bit. Input ready is the inverse of the skid valid flop, so it never
// depends combinationally on out_ready_i.
// Handshake: a transfer completes on a rising edge where valid and ready are
// both high; valid, once raised, holds its data until that transfer.
module pipe_skid_stage_t #(
  parameter int                   BIT_WIDTH     = 8,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 stall_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [BIT_WIDTH-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [BIT_WIDTH-1:0] out_data_o
);

  logic                 main_v_q, main_v_d;
  logic                 skid_v_q, skid_v_d;
  logic [BIT_WIDTH-1:0] main_q, main_d;
  logic [BIT_WIDTH-1:0] skid_q, skid_d;
  logic                 accept;
  logic                 drain;

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;

  // Next-state: refill main from skid first, then from input; park input in
  // skid only when main is held by a stalled consumer.
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    accept   = in_valid_i & ~skid_v_q;
    drain    = main_v_q & out_ready_i;
    if (!stall_i) begin
      if (!main_v_q || drain) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          main_v_d = 1'b1;
          skid_v_d = 1'b0;
        end else if (accept) begin
          main_d   = in_data_i;
          main_v_d = 1'b1;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (accept) begin
        skid_d   = in_data_i;
        skid_v_d = 1'b1;
      end
    end
  end

  // State registers; reset and flush both empty the stage and restore payloads.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= DEFAULT_VALUE;
      skid_q   <= DEFAULT_VALUE;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/pipe_elastic_reg_t.sv
// Elastic pipeline register: a chain of STAGES skid stages with flush, freeze
// and a registered occupancy count. Capacity is 2*STAGES entries.
// Handshake: IN_* and OUT_* transfer on a rising edge where valid and ready
// are both high and STALL is low; STALL forces IN_READY and OUT_VALID low.
module pipe_elastic_reg_t
  import pipe_elastic_reg_t_pkg::*;
#(
  parameter int                   BIT_WIDTH     = 8,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int                   STAGES        = 2,
  localparam int                  CNT_W         = $clog2(2 * STAGES + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLEAR,
  input  logic                 STALL,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [BIT_WIDTH-1:0] IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [BIT_WIDTH-1:0] OUT_DATA,
  output logic [CNT_W-1:0]     OCCUPANCY
);

  // Index k is the input side of stage k; index STAGES is the block output.
  logic [STAGES:0]      chain_valid;
  logic [STAGES:0]      chain_ready;
  logic [BIT_WIDTH-1:0] chain_data [STAGES+1];

  logic             in_hs;
  logic             out_hs;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign chain_valid[0]      = IN_VALID;
  assign chain_data[0]       = IN_DATA;
  assign chain_ready[STAGES] = OUT_READY;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_skid_stage_t #(
      .BIT_WIDTH     (BIT_WIDTH),
      .DEFAULT_VALUE (DEFAULT_VALUE)
    ) u_stage (
      .clk_i       (CLK),
      .rst_i       (RST),
      .clear_i     (CLEAR),
      .stall_i     (STALL),
      .in_valid_i  (chain_valid[k]),
      .in_ready_o  (chain_ready[k]),
      .in_data_i   (chain_data[k]),
      .out_valid_o (chain_valid[k+1]),
      .out_ready_i (chain_ready[k+1]),
      .out_data_o  (chain_data[k+1])
    );
  end

  // Freeze gating is the only combinational path onto the handshake outputs.
  assign IN_READY  = chain_ready[0] & ~STALL;
  assign OUT_VALID = chain_valid[STAGES] & ~STALL;
  assign OUT_DATA  = chain_data[STAGES];
  assign OCCUPANCY = occ_q;

  assign in_hs  = IN_VALID & chain_ready[0] & ~STALL;
  assign out_hs = chain_valid[STAGES] & OUT_READY & ~STALL;

  // Occupancy follows the boundary handshakes; bounded by the chain capacity.
  always_comb begin
    occ_d = CNT_W'(occ_next(int'(occ_q), in_hs, out_hs));
  end

  // Occupancy register, emptied by reset and flush.
  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
